// File: rtl/r4_pkg.sv
// r4_pkg: opcodes, FSM states, datapath select encodings and ALU funct constants for the R4 control unit
package r4_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] SA_PC  = 2'b00;
  localparam logic [1:0] SA_OLD = 2'b01;
  localparam logic [1:0] SA_RS1 = 2'b10;
  localparam logic [1:0] SB_RS2 = 2'b00;
  localparam logic [1:0] SB_IMM = 2'b01;
  localparam logic [1:0] SB_4   = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MDR    = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_HALT
  } state_t;
endpackage

// File: rtl/alu_op_dec.sv
// alu_op_dec: per-state ALU funct select plus legality of the instruction being decoded or executed
module alu_op_dec
  import r4_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [2:0] alu_funct3_o,
  output logic [6:0] alu_funct7_o,
  output logic       legal_o
);
  logic op_legal, r_legal, i_legal;
  always_comb begin
    op_legal = op_i == OP_LW || op_i == OP_SW || op_i == OP_R || op_i == OP_I ||
               (op_i == OP_BEQ && funct3_i == F3_ADD);
    r_legal = (funct3_i == F3_ADD && (funct7_i == F7_BASE || funct7_i == F7_SUB)) ||
              ((funct3_i == F3_AND || funct3_i == F3_OR) && funct7_i == F7_BASE);
    i_legal = funct3_i == F3_ADD || funct3_i == F3_AND || funct3_i == F3_OR;
    alu_funct3_o = (state_i == S_EXECR || state_i == S_EXECI) ? funct3_i : F3_ADD;
    alu_funct7_o = state_i == S_EXECR ? funct7_i : state_i == S_BEQ ? F7_SUB : F7_BASE;
    legal_o = state_i == S_DECODE ? op_legal :
              state_i == S_EXECR  ? r_legal  :
              state_i == S_EXECI  ? i_legal  : 1'b1;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: R4 multicycle FSM driving datapath selects, memory handshake and retired-instruction count
module multicycle_ctrl
  import r4_pkg::*;
#(
  parameter bit RESET_STATE_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        halted,
  output logic [31:0] instret
);
  state_t state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic legal, retire, mreq, mwr, irw, pcw, rw;
  alu_op_dec u_dec (
    .state_i(state_q),
    .op_i(op),
    .funct3_i(funct3),
    .funct7_i(funct7),
    .alu_funct3_o(alu_funct3),
    .alu_funct7_o(alu_funct7),
    .legal_o(legal)
  );
  always_comb begin
    state_d = state_q;
    mreq = 1'b0;
    mwr = 1'b0;
    irw = 1'b0;
    pcw = 1'b0;
    rw = 1'b0;
    retire = 1'b0;
    adr_src = 1'b0;
    imm_src = IMM_I;
    alu_src_a = SA_PC;
    alu_src_b = SB_RS2;
    result_src = RS_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mreq = 1'b1;
        alu_src_b = SB_4;
        result_src = RS_ALU;
        irw = mem_ready;
        pcw = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SA_OLD;
        alu_src_b = SB_IMM;
        imm_src = IMM_B;
        state_d = !legal ? S_HALT :
                  (op == OP_LW || op == OP_SW) ? S_MEMADR :
                  op == OP_R ? S_EXECR :
                  op == OP_I ? S_EXECI : S_BEQ;
      end
      S_MEMADR: begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_IMM;
        imm_src = op == OP_SW ? IMM_S : IMM_I;
        state_d = op == OP_SW ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mreq = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RS_MDR;
        rw = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mreq = 1'b1;
        mwr = 1'b1;
        adr_src = 1'b1;
        retire = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SA_RS1;
        state_d = legal ? S_ALUWB : S_HALT;
      end
      S_EXECI: begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_IMM;
        state_d = legal ? S_ALUWB : S_HALT;
      end
      S_ALUWB: begin
        rw = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SA_RS1;
        pcw = zero;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    instret_d = instret_q + {31'd0, retire};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE_HALT ? S_HALT : S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      instret_q <= instret_d;
    end
  end
  // enables drop combinationally with reset so an in-flight access aborts that same cycle
  assign mem_req = mreq & ~reset;
  assign mem_write = mwr & ~reset;
  assign ir_write = irw & ~reset;
  assign pc_write = pcw & ~reset;
  assign reg_write = rw & ~reset;
  assign halted = state_q == S_HALT;
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle directed vectors for the R4 multicycle controller
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, halted;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_funct3;
  logic [6:0] alu_funct7;
  logic [31:0] instret;
  logic h_mem_req, h_mem_write, h_adr_src, h_ir_write, h_pc_write, h_reg_write, h_halted;
  logic [1:0] h_imm_src, h_alu_src_a, h_alu_src_b, h_result_src;
  logic [2:0] h_alu_funct3;
  logic [6:0] h_alu_funct7;
  logic [31:0] h_instret;
  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .halted(halted), .instret(instret)
  );

  multicycle_ctrl #(.RESET_STATE_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(h_mem_req), .mem_write(h_mem_write),
    .adr_src(h_adr_src), .ir_write(h_ir_write), .pc_write(h_pc_write), .reg_write(h_reg_write),
    .imm_src(h_imm_src), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b),
    .result_src(h_result_src), .alu_funct3(h_alu_funct3), .alu_funct7(h_alu_funct7),
    .halted(h_halted), .instret(h_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic chk;
    logic rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic z;
    logic rdy;
    logic [24:0] ctl;
    logic [31:0] ir;
  } vec_t;

  vec_t q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;
  logic [24:0] act;
  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src,
                alu_src_a, alu_src_b, result_src, alu_funct3, alu_funct7, halted};

  function automatic logic [24:0] pk(input logic mq, input logic mw, input logic ad,
                                     input logic iw, input logic pw, input logic rw,
                                     input logic [1:0] im, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] rs,
                                     input logic [2:0] f3, input logic [6:0] f7, input logic h);
    return {mq, mw, ad, iw, pw, rw, im, a, b, rs, f3, f7, h};
  endfunction

  function automatic logic [24:0] e_fetch(input logic r);
    return pk(1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_dec();
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_madr(input logic s);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, s}, 2'b10, 2'b01, 2'b00, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_mrd();
    return pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_mwb();
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_mwr(input logic en);
    return pk(en, en, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_xr(input logic [2:0] f3, input logic [6:0] f7);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, f3, f7, 1'b0);
  endfunction
  function automatic logic [24:0] e_xi(input logic [2:0] f3);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, f3, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_awb();
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 7'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_beq(input logic z);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 7'b0100000, 1'b0);
  endfunction
  function automatic logic [24:0] e_halt();
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 7'b0, 1'b1);
  endfunction

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    cur_op = o;
    cur_f3 = f3;
    cur_f7 = f7;
  endtask

  task automatic row(input string nm, input logic rst, input logic z, input logic rdy,
                     input logic [24:0] ctl, input logic [31:0] ir, input logic chk);
    vec_t t;
    t.nm = nm; t.chk = chk; t.rst = rst; t.op = cur_op; t.f3 = cur_f3; t.f7 = cur_f7;
    t.z = z; t.rdy = rdy; t.ctl = ctl; t.ir = ir;
    q.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    reset = t.rst; op = t.op; funct3 = t.f3; funct7 = t.f7; zero = t.z; mem_ready = t.rdy;
    #2;
    if (t.chk) begin
      checks++;
      if (act !== t.ctl) begin
        failures++;
        $display("FAIL %s ctl got %b want %b", t.nm, act, t.ctl);
      end
      checks++;
      if (instret !== t.ir) begin
        failures++;
        $display("FAIL %s instret got %h want %h", t.nm, instret, t.ir);
      end
    end
  endtask

  task automatic flush();
    foreach (q[i]) apply(q[i]);
    q.delete();
  endtask

  initial begin
    mem_ready = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if ({mem_req, mem_write, ir_write, pc_write, reg_write} !== 5'b0) begin
      failures++;
      $display("FAIL reset_enables got %b want 00000",
               {mem_req, mem_write, ir_write, pc_write, reg_write});
    end
    @(negedge clk);
    reset = 1'b1;

    ins(7'b0110011, 3'b000, 7'b0000000);
    row("add_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd0, 1'b1);
    row("add_dec", 1'b0, 1'b1, 1'b1, e_dec(), 32'd0, 1'b1);
    row("add_execr", 1'b0, 1'b0, 1'b1, e_xr(3'b000, 7'b0), 32'd0, 1'b1);
    row("add_aluwb", 1'b0, 1'b0, 1'b1, e_awb(), 32'd0, 1'b1);
    ins(7'b0000011, 3'b010, 7'b0000000);
    for (int i = 0; i < 3; i++) row("lw_fetch_wait", 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 32'd1, 1'b1);
    row("lw_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd1, 1'b1);
    row("lw_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd1, 1'b1);
    row("lw_memadr", 1'b0, 1'b0, 1'b1, e_madr(1'b0), 32'd1, 1'b1);
    for (int i = 0; i < 3; i++) row("lw_memrd_wait", 1'b0, 1'b0, 1'b0, e_mrd(), 32'd1, 1'b1);
    row("lw_memrd", 1'b0, 1'b0, 1'b1, e_mrd(), 32'd1, 1'b1);
    row("lw_memwb", 1'b0, 1'b0, 1'b1, e_mwb(), 32'd1, 1'b1);
    ins(7'b1100011, 3'b000, 7'b0000000);
    row("beq1_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd2, 1'b1);
    row("beq1_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd2, 1'b1);
    row("beq_taken", 1'b0, 1'b1, 1'b1, e_beq(1'b1), 32'd2, 1'b1);
    row("beq0_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd3, 1'b1);
    row("beq0_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd3, 1'b1);
    row("beq_not_taken", 1'b0, 1'b0, 1'b1, e_beq(1'b0), 32'd3, 1'b1);
    ins(7'b0010011, 3'b110, 7'b0100000);
    row("ori_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd4, 1'b1);
    row("ori_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd4, 1'b1);
    row("ori_execi", 1'b0, 1'b0, 1'b1, e_xi(3'b110), 32'd4, 1'b1);
    row("ori_aluwb", 1'b0, 1'b0, 1'b1, e_awb(), 32'd4, 1'b1);
    ins(7'b0100011, 3'b010, 7'b0000000);
    row("sw_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd5, 1'b1);
    row("sw_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd5, 1'b1);
    row("sw_memadr", 1'b0, 1'b0, 1'b1, e_madr(1'b1), 32'd5, 1'b1);
    row("sw_memwr_wait", 1'b0, 1'b0, 1'b0, e_mwr(1'b1), 32'd5, 1'b1);
    row("sw_reset_midwait", 1'b1, 1'b0, 1'b1, e_mwr(1'b0), 32'd5, 1'b1);
    row("post_reset_fetch", 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 32'd0, 1'b1);
    ins(7'b0110011, 3'b001, 7'b0000000);
    row("sll_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd0, 1'b1);
    row("sll_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd0, 1'b1);
    row("sll_execr", 1'b0, 1'b0, 1'b1, e_xr(3'b001, 7'b0), 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) row("sll_halt", 1'b0, 1'b1, 1'b1, e_halt(), 32'd0, 1'b1);
    row("reset", 1'b1, 1'b0, 1'b0, e_halt(), 32'd0, 1'b0);
    ins(7'b1111111, 3'b000, 7'b0000000);
    row("badop_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'd0, 1'b1);
    row("badop_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) row("badop_halt", 1'b0, 1'b1, 1'b1, e_halt(), 32'd0, 1'b1);
    row("reset", 1'b1, 1'b0, 1'b0, e_halt(), 32'd0, 1'b0);
    flush();

    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    ins(7'b0100011, 3'b010, 7'b0000000);
    row("wrap_fetch_wait", 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 32'hFFFF_FFFF, 1'b1);
    flush();
    release dut.instret_q;
    row("wrap_fetch", 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 32'hFFFF_FFFF, 1'b1);
    row("wrap_dec", 1'b0, 1'b0, 1'b1, e_dec(), 32'hFFFF_FFFF, 1'b1);
    row("wrap_memadr", 1'b0, 1'b0, 1'b1, e_madr(1'b1), 32'hFFFF_FFFF, 1'b1);
    row("wrap_memwr", 1'b0, 1'b0, 1'b1, e_mwr(1'b1), 32'hFFFF_FFFF, 1'b1);
    row("wrap_done", 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 32'h0000_0000, 1'b1);
    flush();

    checks++;
    if (h_halted !== 1'b1 || {h_mem_req, h_ir_write, h_pc_write, h_reg_write} !== 4'b0 ||
        h_instret !== 32'd0) begin
      failures++;
      $display("FAIL reset_halt_param got halted=%b en=%b instret=%h want halted=1 en=0000 instret=0",
               h_halted, {h_mem_req, h_ir_write, h_pc_write, h_reg_write}, h_instret);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit for the R4 core. It sequences fetch, decode, execute, memory and writeback for the RV32 subset the ALU supports.
- It drives the ALU's funct3/funct7 operation select and the datapath mux selects and enables.
- It consumes the ALU zero flag for branch resolution.
- It owns a req/ready handshake to unified instruction/data memory and a retired-instruction counter.

Parameters:
- RESET_STATE_HALT, 0, when 1 the FSM leaves reset into HALT instead of FETCH (bring-up aid).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  opcode field of instruction register
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- zero  in  1  ALU zero flag (combinational from current ALU inputs)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access requested
- mem_write  out  1  access is a store (valid only with mem_req)
- adr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write  out  1  load instruction register and old_pc
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- imm_src  out  2  00 I, 01 S, 10 B
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- result_src  out  2  00 ALU-out register, 01 memory-data register, 10 ALU result direct
- alu_funct3  out  3  to ALU funct3
- alu_funct7  out  7  to ALU funct7
- halted  out  1  sticky illegal-instruction indicator
- instret  out  32  retired-instruction count

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset:
  - State becomes FETCH, or HALT if RESET_STATE_HALT=1.
  - instret=0; halted=0, or 1 if RESET_STATE_HALT.
  - While reset is high, every enable (mem_req, mem_write, ir_write, pc_write, reg_write) is forced to 0.
- Outputs are Moore decodes of state, except pc_write, ir_write and state advance, which are qualified by mem_ready or zero as listed below.
- Unlisted selects are 0. ADD means alu_funct3=000, alu_funct7=0000000. SUB means alu_funct3=000, alu_funct7=0100000.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - On mem_ready: ir_write=1, pc_write=1 (PC+4), go to DECODE. Otherwise hold, with every enable except mem_req held at 0.
- DECODE:
  - alu_src_a=01, alu_src_b=01, imm_src=10, ADD (branch target into ALU-out).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 with funct3=000 -> BEQ
    - anything else -> HALT
- MEMADR:
  - alu_src_a=10, alu_src_b=01, ADD.
  - imm_src=00 for lw, 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB, else hold.
- MEMWB: result_src=01, reg_write=1, instret+1, go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready: instret+1, go to FETCH.
- EXECR:
  - alu_src_a=10, alu_src_b=00, alu_funct3/alu_funct7 pass through from the instruction.
  - Legal combinations only: add 000/0000000, sub 000/0100000, and 111/0000000, or 110/0000000. Any other combination goes to HALT.
  - Otherwise go to ALUWB.
- EXECI:
  - alu_src_a=10, alu_src_b=01, imm_src=00, alu_funct3=funct3, alu_funct7=0.
  - Legal funct3: 000, 110, 111. Any other goes to HALT; otherwise go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instret+1, go to FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, SUB, result_src=00.
  - pc_write=zero, instret+1, go to FETCH.
- HALT:
  - halted=1, all enables 0, alu_funct fields 0.
  - Terminal until reset. instret is unchanged and the illegal instruction does not retire.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- mem_ready is sampled only while mem_req=1. A multi-cycle wait never re-asserts ir_write or pc_write.
- instret wraps from FFFFFFFF to 0.
- Reset asserted mid-wait (mem_req high) drops mem_req on the same cycle. No partial writeback.

Decomposition:
- r4_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ)
  - state enum
  - select encodings for imm_src, alu_src_a, alu_src_b and result_src
  - ALU funct constants (F3_ADD, F3_AND, F3_OR, F7_BASE, F7_SUB)
- One sub-module, alu_op_dec, is combinational. It maps state, op, funct3 and funct7 to alu_funct3, alu_funct7 and a legal flag.

Test Plan:
- add x3,x1,x2 with mem_ready=1 every cycle:
  - States are FETCH, DECODE, EXECR, ALUWB, taking 4 cycles.
  - ALUWB has reg_write=1 and result_src=00. EXECR drives alu_funct7=0000000.
  - instret goes 0 -> 1.
- lw with mem_ready low for 3 cycles in both FETCH and MEMREAD:
  - mem_req stays high throughout. ir_write pulses exactly once.
  - MEMWB has result_src=01. Total is 11 cycles.
- beq:
  - With zero=1 in BEQ: pc_write=1 and the ALU is driven with SUB.
  - With zero=0 on a repeat: pc_write=0. instret increments in both cases.
- Illegal inputs:
  - R-type funct3=001 -> HALT after EXECR, halted=1, no reg_write.
  - Any opcode 1111111 -> HALT from DECODE.
  - Both remain halted for 20 cycles.
- instret preloaded near wrap (run 2^32-1 retirements via force or backdoor) -> the next sw retirement gives 00000000.
- reset asserted during a MEMWRITE wait -> mem_req and mem_write are 0 that cycle. Next state is FETCH and instret=0.
